// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller in front of a single-port synchronous SRAM,
// with round-robin arbitration between a push stream and pop requests.
module sram_fifo_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop_req,
    output logic          pop_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          sram_cs,
    output logic          sram_we,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);
    localparam int DEPTH = 2**AW;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          prio_q, prio_d, rd_valid_q, rd_valid_d;
    logic          push_ok, pop_ok, push_gnt, pop_gnt;

    // prio_q=0 favours pop on a conflict, prio_q=1 favours push
    always_comb begin
        full       = count_q == (AW+1)'(DEPTH);
        empty      = count_q == '0;
        push_ok    = push_valid && !full;
        pop_ok     = pop_req && !empty;
        push_ready = !rst && !full && !(pop_ok && !prio_q);
        pop_ready  = !rst && !empty && !(push_ok && prio_q);
        push_gnt   = push_valid && push_ready;
        pop_gnt    = pop_req && pop_ready;
    end

    always_comb begin
        wr_ptr_d   = push_gnt ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_gnt ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = push_gnt ? count_q + (AW+1)'(1) : pop_gnt ? count_q - (AW+1)'(1) : count_q;
        prio_d     = prio_q ^ (push_ok && pop_ok);
        rd_valid_d = pop_gnt;
    end

    always_comb begin
        sram_cs   = push_gnt || pop_gnt;
        sram_we   = push_gnt;
        sram_rd   = pop_gnt;
        sram_addr = push_gnt ? wr_ptr_q : rd_ptr_q;
        sram_din  = push_data;
        rd_data   = sram_dout;
        rd_valid  = rd_valid_q;
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prio_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            prio_q     <= prio_d;
            rd_valid_q <= rd_valid_d;
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed test-plan sequences plus random traffic,
// checked every cycle against a queue-based FIFO model.
module tb_sram_fifo_ctrl;
    logic       clk, rst, push_valid, pop_req;
    logic [7:0] push_data, rd_data, sram_addr, sram_din, sram_dout;
    logic       push_ready, pop_ready, rd_valid, full, empty;
    logic       sram_cs, sram_we, sram_rd;
    logic [8:0] count;
    logic [7:0] mem [256];

    int n_chk = 0, n_fail = 0;

    logic [7:0] q[$];
    bit         mprio = 0, mrv = 0, armed = 0;
    logic [7:0] mrd = 0, mwp = 0, mrp = 0;

    sram_fifo_ctrl #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_req(pop_req), .pop_ready(pop_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .full(full), .empty(empty),
        .count(count), .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always_ff @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
        else if (sram_cs && sram_rd) sram_dout <= mem[sram_addr];
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit pv, input logic [7:0] pd, input bit pr, input bit r);
        int n;
        bit fl, em, pe, qe, prdy, qrdy, pw, qw;
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        rst        = r;
        @(negedge clk);
        n    = q.size();
        fl   = n == 256;
        em   = n == 0;
        pe   = pv && !fl;
        qe   = pr && !em;
        prdy = !r && !fl && (!qe || mprio);
        qrdy = !r && !em && (!pe || !mprio);
        pw   = pv && prdy;
        qw   = pr && qrdy;
        if (armed) begin
            chk("count", count, n);
            chk("full", full, fl);
            chk("empty", empty, em);
            chk("push_ready", push_ready, prdy);
            chk("pop_ready", pop_ready, qrdy);
            chk("rd_valid", rd_valid, mrv);
            if (mrv) chk("rd_data", rd_data, mrd);
            chk("sram_cs", sram_cs, pw || qw);
            chk("sram_we", sram_we, pw);
            chk("sram_rd", sram_rd, qw);
            chk("we_rd_excl", sram_we && sram_rd, 0);
            chk("sram_addr", sram_addr, pw ? mwp : mrp);
            chk("sram_din", sram_din, pd);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            mwp = 0; mrp = 0; mprio = 0; mrv = 0;
        end else begin
            if (pw) begin q.push_back(pd); mwp++; end
            if (qw) begin mrd = q.pop_front(); mrp++; end
            mrv = qw;
            if (pe && qe) mprio = !mprio;
        end
        armed = 1;
        #1;
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 257; i++) step(1, 8'(i), 0, 0);
        chk("fill_count", count, 256);
        for (int i = 0; i < 257; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 8'hA5, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'(i + 8'h40), 0, 0);
        repeat (6) step(1, 8'($urandom), 1, 0);
        repeat (5) step(0, 0, 1, 0);
        step(1, 8'h5C, 0, 0);
        step(1, 8'h5D, 1, 0);
        step(0, 0, 1, 1);
        step(1, 8'h77, 1, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'hEE, 1, 0);
        step(1, 8'hEE, 0, 0);
        chk("refill_count", count, 256);
        step(1, 8'hEF, 1, 0);
        step(1, 8'hEF, 1, 0);
        for (int ph = 0; ph < 6; ph++) begin
            int pp, pq;
            pp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 30 : 60;
            pq = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 90 : 60;
            for (int i = 0; i < 500; i++)
                step($urandom_range(0, 99) < pp, 8'($urandom), $urandom_range(0, 99) < pq,
                     $urandom_range(0, 299) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

FIFO controller that sits directly upstream of the single-port synchronous SRAM (8-bit address, 8-bit data, `cs`/`we`/`rd` strobes, registered read data). It turns a push stream and a pop request stream into SRAM write and read cycles and keeps head/tail pointers and an occupancy count. Push and pop conflicts are arbitrated round-robin. Read data returns to the consumer one cycle after the pop is granted.

## Interface
Parameters:
- `AW`, 8: SRAM address width; depth is `DEPTH = 2**AW`.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  producer has a word on `push_data`.
- `push_data`  in  DW  word to enqueue.
- `push_ready`  out  1  push is accepted this cycle when `push_valid && push_ready`.
- `pop_req`  in  1  consumer requests one word.
- `pop_ready`  out  1  pop is granted this cycle when `pop_req && pop_ready`.
- `rd_valid`  out  1  `rd_data` is valid this cycle (one-cycle pulse).
- `rd_data`  out  DW  dequeued word, equal to `sram_dout`.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  AW+1  current occupancy.
- `sram_cs`, `sram_we`, `sram_rd`  out  1 each  SRAM strobes.
- `sram_addr`  out  AW  SRAM address.
- `sram_din`  out  DW  SRAM write data, equal to `push_data`.
- `sram_dout`  in  DW  SRAM registered read data.

## Operation
- State: `wr_ptr`, `rd_ptr` (AW bits each, wrap modulo DEPTH), `count` (AW+1 bits), `prio` (1 bit), `rd_valid` register.
- Eligibility:
  - `push_ok = push_valid && !full`.
  - `pop_ok = pop_req && !empty`.
- Arbitration (combinational) when both are eligible:
  - `prio == 0`: pop wins.
  - `prio == 1`: push wins.
  - `prio` toggles only on a cycle where a conflict occurred. A lone request always wins and leaves `prio` unchanged.
- `push_ready = !rst && !full && !(pop_ok && prio == 0)`.
- `pop_ready = !rst && !empty && !(push_ok && prio == 1)`.
- Push grant, same cycle:
  - Drive `sram_cs=1`, `sram_we=1`, `sram_rd=0`, `sram_addr=wr_ptr`.
  - At the edge: `wr_ptr++`, `count++`.
- Pop grant, same cycle:
  - Drive `sram_cs=1`, `sram_we=0`, `sram_rd=1`, `sram_addr=rd_ptr`.
  - At the edge: `rd_ptr++`, `count--`, `rd_valid<=1`.
- No grant: `sram_cs=sram_we=sram_rd=0`, `sram_addr=rd_ptr`, `rd_valid<=0` at the edge.
- Exactly one SRAM operation per cycle. `we` and `rd` are never both high.
- Pop while empty is ignored (`pop_ready=0`), even if a push is granted in the same cycle. There is no bypass path.
- Push while full is ignored (`push_ready=0`). Data is not dropped; the producer holds it.
- No backpressure on `rd_valid`; the consumer must accept the word in that cycle.

## Timing
- Reset, at the first edge with `rst=1`:
  - `wr_ptr=rd_ptr=0`, `count=0`, `prio=0`, `rd_valid=0`.
  - Hence `empty=1`, `full=0`.
- While `rst=1`: `push_ready=pop_ready=0`, all SRAM strobes 0. Contents of the SRAM are not cleared.
- Reset mid-operation: a pop granted in the cycle before `rst` still raises `rd_valid` for one cycle. A pop cannot be granted in a cycle where `rst=1`. After reset, `rd_valid=0` and all in-flight state is discarded.
- Latency:
  - Push accepted in cycle N is visible in `count`/`empty` in cycle N+1.
  - Pop granted in cycle N gives `rd_valid=1` and `rd_data=sram_dout` in cycle N+1.
- A word pushed in cycle N can be popped in cycle N+1 at the earliest.
- Throughput: one operation per cycle. Under a continuous conflict, push and pop alternate and each gets 50%.
- `full`, `empty` and `count` are decoded from registered state. `push_ready` and `pop_ready` depend combinationally on `push_valid`/`pop_req`.
- Pointer wrap: DEPTH-1 to 0. `count` never exceeds DEPTH and never goes below 0.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times:
  - `rd_valid` pulses one cycle after each grant with 0x11, 0x22, 0x33.
  - `count` goes 1, 2, 3, 2, 1, 0; `empty` is 1 at the end.
- Fill with 256 pushes of `i`:
  - `full=1` and `count=256`; the 257th push sees `push_ready=0`.
  - Pop all 256: data 0..255 in order; `wr_ptr`/`rd_ptr` wrap back to 0.
- Empty FIFO, `pop_req=1` and `push_valid=1` with 0xA5 in the same cycle:
  - Push granted, no `rd_valid`.
  - Next cycle the pop is granted; the cycle after that, `rd_data=0xA5`.
- `count=4`, hold `push_valid=1` and `pop_req=1` for 6 cycles (`prio=0` after reset):
  - Grants are pop, push, pop, push, pop, push.
  - `count` stays between 3 and 4; no cycle has both `sram_we` and `sram_rd` high.
- Pop granted in cycle N, `rst=1` in cycle N+1 for 2 cycles:
  - `rd_valid=1` in N+1 only; afterwards `count=0`, `empty=1`, ready signals 0 while `rst` is high.
- Full FIFO with `push_valid` and `pop_req` both high:
  - Only the pop is eligible and is granted; `prio` does not toggle.
  - Next cycle the push is accepted; `count` returns to 256.
